// File: rtl/addr_stack_pkg.sv
// rtl/addr_stack_pkg.sv - op codes, FSM states and sizing shared by the address stack arbiter
package addr_stack_pkg;

  localparam logic [1:0] OP_POP   = 2'b00;
  localparam logic [1:0] OP_PUSH1 = 2'b01;
  localparam logic [1:0] OP_PUSH2 = 2'b11;

  localparam int STACK_SIZE_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // 2'b10 is an alias for push one
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == 2'b10) ? OP_PUSH1 : op;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin arbiter; ARB_FIXED_PRIO_EN selects fixed priority to requester 0
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, update};
  assign grant     = req[0] ? 2'b01 : {req[1], 1'b0};
`else
  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  // last holds the requester granted most recently; reset favours requester 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (update) last <= grant[1];
  end
`endif

endmodule

// File: rtl/addr_stack_arbiter.sv
// rtl/addr_stack_arbiter.sv - shares the address stack between decoder and DMA (ARB_FIXED_PRIO_EN: fixed priority)
module addr_stack_arbiter
  import addr_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STACK_SIZE = STACK_SIZE_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      req_valid,
  input  logic [1:0]                      req0_op,
  input  logic [1:0]                      req1_op,
  input  logic [DATA_WIDTH-1:0]           req0_data,
  input  logic [DATA_WIDTH-1:0]           req1_data,
  output logic [1:0]                      req_ready,
  output logic                            rsp_valid,
  output logic                            rsp_id,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            stk_en,
  output logic [1:0]                      stk_ctl,
  output logic [DATA_WIDTH-1:0]           stk_data,
  input  logic [DATA_WIDTH-1:0]           stk_rdata,
  input  logic                            stk_wait,
  output logic [$clog2(STACK_SIZE+1)-1:0] depth
);

  localparam int DW = $clog2(STACK_SIZE + 1);
  localparam logic [DW:0] CAP = (DW + 1)'(STACK_SIZE);

  state_t                state;
  logic [1:0]            grant;
  logic [1:0]            win_op;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  id_q;
  logic                  take;
  logic                  legal;
  logic [DW:0]           depth_x;

  assign take      = (state == ST_IDLE) && (req_valid != 2'b00);
  assign req_ready = (take && !rst) ? grant : 2'b00;
  assign depth_x   = {1'b0, depth};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (take),
    .grant  (grant)
  );

  always_comb begin
    win_op   = norm_op(grant[1] ? req1_op : req0_op);
    win_data = grant[1] ? req1_data : req0_data;
    legal    = 1'b0;
    case (win_op)
      OP_POP:   legal = (depth != '0);
      OP_PUSH2: legal = (depth_x + (DW + 1)'(2)) <= CAP;
      default:  legal = (depth_x + (DW + 1)'(1)) <= CAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      depth     <= '0;
      op_q      <= OP_POP;
      id_q      <= 1'b0;
      stk_en    <= 1'b0;
      stk_ctl   <= 2'b00;
      stk_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      stk_en    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            op_q <= win_op;
            id_q <= grant[1];
            if (legal) begin
              state    <= ST_ISSUE;
              stk_en   <= 1'b1;
              stk_ctl  <= win_op;
              stk_data <= win_data;
            end else begin
              // rejected without touching the stack
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant[1];
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        ST_ISSUE: begin
          stk_ctl  <= 2'b00;
          stk_data <= '0;
          case (op_q)
            OP_POP:   depth <= depth - DW'(1);
            OP_PUSH2: depth <= depth + DW'(2);
            default:  depth <= depth + DW'(1);
          endcase
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_err   <= stk_wait;
          rsp_data  <= (op_q == OP_POP && !stk_wait) ? stk_rdata : '0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_id   <= 1'b0;
          rsp_err  <= 1'b0;
          rsp_data <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_stack_arbiter.sv
// tb/tb_addr_stack_arbiter.sv - directed bench with a cycle-level expectation model for addr_stack_arbiter
module tb_addr_stack_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        stk_en;
  logic [1:0]  stk_ctl;
  logic [15:0] stk_data;
  logic [15:0] stk_rdata;
  logic        stk_wait;
  logic [1:0]  depth;

  int vecs = 0;
  int errs = 0;

  addr_stack_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req0_op   (req0_op),
    .req1_op   (req1_op),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .stk_en    (stk_en),
    .stk_ctl   (stk_ctl),
    .stk_data  (stk_data),
    .stk_rdata (stk_rdata),
    .stk_wait  (stk_wait),
    .depth     (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: one transaction at a time, scheduled by the published latencies
  int          n = 0;
  int          m_depth, busy_end, stk_cyc, settle_cyc, rsp_cyc, depth_cyc, e_delta, w;
  bit          m_last, e_id, e_err, e_pop, lgl;
  logic [1:0]  e_ctl, mop, g;
  logic [15:0] e_sdata, e_rdata, md;

  always @(negedge clk) begin
    n++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_stk_en", stk_en, 0);
      chk("rst_stk_ctl", stk_ctl, 0);
      chk("rst_stk_data", stk_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_depth", depth, 0);
      m_depth = 0; m_last = 1'b1; busy_end = -1;
      stk_cyc = -1; settle_cyc = -1; rsp_cyc = -1; depth_cyc = -1;
    end else begin
      if (n == depth_cyc) m_depth += e_delta;
      if (n == settle_cyc) begin
        e_err   = stk_wait;
        e_rdata = (e_pop && !stk_wait) ? stk_rdata : 16'h0;
      end
      g = 2'b00;
      if (n > busy_end && req_valid != 2'b00) begin
        if (req_valid == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = m_last ? 0 : 1;
`endif
        end else begin
          w = req_valid[1] ? 1 : 0;
        end
        m_last = (w == 1);
        g      = (w == 1) ? 2'b10 : 2'b01;
        mop    = (w == 1) ? req1_op : req0_op;
        if (mop == 2'b10) mop = 2'b01;
        md      = (w == 1) ? req1_data : req0_data;
        e_delta = (mop == 2'b00) ? -1 : (mop == 2'b01) ? 1 : 2;
        lgl     = (mop == 2'b00) ? (m_depth > 0) : (m_depth + e_delta <= 3);
        e_id    = (w == 1);
        e_pop   = (mop == 2'b00);
        if (lgl) begin
          stk_cyc = n + 1; depth_cyc = n + 2; settle_cyc = n + 2;
          rsp_cyc = n + 3; busy_end = n + 3;
          e_ctl = mop; e_sdata = md;
        end else begin
          rsp_cyc = n + 1; busy_end = n + 1;
          e_err = 1'b1; e_rdata = 16'h0;
        end
      end
      chk("req_ready", req_ready, g);
      chk("stk_en", stk_en, (n == stk_cyc));
      if (n == stk_cyc) begin
        chk("stk_ctl", stk_ctl, e_ctl);
        chk("stk_data", stk_data, e_sdata);
      end
      chk("rsp_valid", rsp_valid, (n == rsp_cyc));
      if (n == rsp_cyc) begin
        chk("rsp_id", rsp_id, e_id);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_data", rsp_data, e_rdata);
      end
      chk("depth", depth, m_depth);
    end
  end

  task automatic txn(input int id, input logic [1:0] op, input logic [15:0] d,
                     output int lat, output logic err, output logic [15:0] data, output logic rid);
    bit got;
    lat = -1; err = 1'b0; data = 16'h0; rid = 1'b0; got = 1'b0;
    @(posedge clk); #2;
    req_valid[id] = 1'b1;
    if (id == 0) begin req0_op = op; req0_data = d; end
    else begin req1_op = op; req1_data = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
      req_valid[id] = 1'b0;
      return;
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      if (k == 1) req_valid[id] = 1'b0;
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; err = rsp_err; data = rsp_data; rid = rsp_id;
        break;
      end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask

  int          lat, rcount;
  logic        err, rid;
  logic [15:0] data;
  int          gseq[$];

  initial begin
    rst = 1'b1; req_valid = 2'b00; req0_op = 2'b00; req1_op = 2'b00;
    req0_data = 16'h0; req1_data = 16'h0; stk_rdata = 16'hFFFF; stk_wait = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_depth", depth, 0);

    txn(1, 2'b00, 16'h0, lat, err, data, rid);
    chk("pop_empty_lat", lat, 1);
    chk("pop_empty_err", err, 1);
    chk("pop_empty_id", rid, 1);
    chk("pop_empty_data", data, 0);

    txn(0, 2'b01, 16'hA0C3, lat, err, data, rid);
    chk("push1_lat", lat, 3);
    chk("push1_err", err, 0);
    chk("push1_data", data, 0);
    chk("push1_depth", depth, 1);

    stk_rdata = 16'h5012;
    txn(1, 2'b00, 16'h0, lat, err, data, rid);
    chk("pop_lat", lat, 3);
    chk("pop_data", data, 16'h5012);
    chk("pop_depth", depth, 0);

    txn(0, 2'b11, 16'h1111, lat, err, data, rid);
    chk("push2_depth", depth, 2);
    txn(0, 2'b11, 16'h2222, lat, err, data, rid);
    chk("push2_full_lat", lat, 1);
    chk("push2_full_err", err, 1);
    chk("push2_full_depth", depth, 2);

    txn(1, 2'b10, 16'h1234, lat, err, data, rid);
    chk("push1_alias_err", err, 0);
    chk("push1_alias_depth", depth, 3);
    txn(0, 2'b01, 16'h3333, lat, err, data, rid);
    chk("push1_full_err", err, 1);
    chk("push1_full_depth", depth, 3);

    stk_wait = 1'b1; stk_rdata = 16'hBEEF;
    txn(1, 2'b00, 16'h0, lat, err, data, rid);
    chk("wait_err", err, 1);
    chk("wait_data", data, 0);
    stk_wait = 1'b0;

    // both requesters held valid: two push-ones at depth 2, then four pops
    @(posedge clk); #2;
    req0_op = 2'b01; req1_op = 2'b01; req0_data = 16'h0A0A; req1_data = 16'h0B0B;
    req_valid = 2'b11;
    for (int c = 0; c < 100 && gseq.size() < 6; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        gseq.push_back(req_ready[1] ? 1 : 0);
        if (gseq.size() == 2) begin
          @(posedge clk); #2;
          req0_op = 2'b00; req1_op = 2'b00;
        end
      end
    end
    @(posedge clk); #2;
    req_valid = 2'b00;
    chk("grant_count", gseq.size(), 6);
    for (int i = 0; i < gseq.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk("grant_order", gseq[i], 0);
`else
      chk("grant_order", gseq[i], i % 2);
`endif
    end
    repeat (4) @(negedge clk);
    chk("contend_depth", depth, 0);

    // reset during SETTLE aborts the push
    @(posedge clk); #2;
    req0_op = 2'b01; req0_data = 16'h55AA; req_valid = 2'b01;
    lat = 0;
    for (int i = 0; i < 20 && lat == 0; i++) begin
      @(negedge clk);
      if (req_ready[0]) lat = 1;
    end
    chk("abort_grant", lat, 1);
    @(posedge clk); #2;
    req_valid = 2'b00;
    @(posedge clk); #2;
    chk("abort_pre_depth", depth, 1);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_stk_en", stk_en, 0);
    chk("abort_depth", depth, 0);
    rcount = 0;
    repeat (2) begin @(negedge clk); rcount += int'(rsp_valid); end
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (5) begin @(negedge clk); rcount += int'(rsp_valid); end
    chk("abort_no_rsp", rcount, 0);
    chk("abort_final_depth", depth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/addr_stack_arbiter.md
Name: addr_stack_arbiter

Overview:
- Shares the 3-entry address stack between two requesters: requester 0 is the instruction decoder and requester 1 is the DMA engine.
- Sequences one stack command at a time and keeps a mirror of stack occupancy.
- Rejects illegal pops (stack empty) and illegal pushes (not enough space) without touching the stack.
- Returns pop data, or an error, to the requester that issued the operation.

Parameters:
- DATA_WIDTH, 16, width of the request, stack and response data paths.
- STACK_SIZE, 3, stack capacity in entries; the occupancy counter is sized to hold 0..STACK_SIZE.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  2  per-requester request valid
- req0_op  in  2  requester 0 op: 00 pop, 01 push one, 11 push two (10 is treated as 01)
- req1_op  in  2  requester 1 op, same encoding as req0_op
- req0_data  in  DATA_WIDTH  requester 0 push data
- req1_data  in  DATA_WIDTH  requester 1 push data
- req_ready  out  2  one-hot acceptance, high for one cycle
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  1  index of the responding requester
- rsp_err  out  1  operation rejected (empty/full) or stack signalled a stall
- rsp_data  out  DATA_WIDTH  popped address; 0 for pushes and errors
- stk_en  out  1  stack command strobe; the stack holds all state while this is low
- stk_ctl  out  2  stack command code (same encoding as the op fields)
- stk_data  out  DATA_WIDTH  push data to the stack
- stk_rdata  in  DATA_WIDTH  stack registered output, valid one cycle after stk_en
- stk_wait  in  1  stack full/stall indication
- depth  out  2  occupancy mirror, 0..3

Behaviour:
Reset (asynchronous):
- All outputs 0; FSM in IDLE; round-robin pointer favours requester 0; depth 0.

FSM has four states: IDLE, ISSUE, SETTLE, RESP.
- IDLE:
  - If any req_valid is set, the arbiter picks a winner, pulses req_ready for that requester, and latches its op and data.
  - Legality check on the latched op:
    - pop with depth==0 is illegal;
    - push one with depth==STACK_SIZE is illegal;
    - push two with depth>STACK_SIZE-2 is illegal.
  - Legal: go to ISSUE. Illegal: go to RESP with rsp_err=1 and no stack command.
- ISSUE:
  - stk_en=1 for exactly one cycle, with stk_ctl and stk_data taken from the latch.
  - depth updates on this edge: pop -1, push one +1, push two +2.
  - Go to SETTLE.
- SETTLE:
  - Capture stk_rdata into the response register (pop only).
  - If stk_wait=1, set the error flag for this response.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id, rsp_err and rsp_data.
  - Go to IDLE.

Latency and throughput:
- Legal op: rsp_valid 3 cycles after the req_ready cycle.
- Illegal op: rsp_valid 1 cycle after the req_ready cycle.
- At most one outstanding operation. req_valid must be held until req_ready; data is sampled only in the req_ready cycle.

Arbitration:
- Round-robin. When both requesters are valid, the one not granted last wins.
- A single valid requester always wins, and the pointer updates only on a grant.

Boundary conditions:
- Two simultaneous requests with depth==2 where both want push one: the winner is accepted; the loser is then rejected as full once it wins the next IDLE.
- rsp_data is 0 for pushes and for errors.
- depth never wraps; illegal ops leave depth unchanged.
- rst mid-operation aborts the operation: no response is issued and depth returns to 0. The stack is reset by the same rst.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins a simultaneous request and the round-robin pointer is removed.
- Undefined: round-robin as described above.

Decomposition:
- Package addr_stack_pkg holds:
  - op code localparams: OP_POP=2'b00, OP_PUSH1=2'b01, OP_PUSH2=2'b11;
  - the FSM state enum;
  - STACK_SIZE default.
- Sub-module rr_arb2: 2-way round-robin arbiter with a grant pointer, implementing the ARB_FIXED_PRIO_EN variant as well.

Test Plan:
- After reset, req0 push one with data 16'hA0C3 -> stk_en with stk_ctl=01 and stk_data=A0C3 one cycle after grant; rsp_valid 3 cycles after grant with rsp_err=0; depth=1.
- At depth 0, req1 pop -> no stk_en; rsp_valid one cycle after grant with rsp_err=1, rsp_id=1, rsp_data=0.
- At depth 2, req0 push two -> rejected with rsp_err=1 and depth stays 2. A following push one is accepted and depth becomes 3.
- Both requesters valid continuously -> grants alternate 0,1,0,1. With ARB_FIXED_PRIO_EN -> grants are 0,0,0.
- At depth 1, pop with stk_rdata driven to 16'h5012 in SETTLE -> rsp_data=5012, depth=0.
- rst asserted during SETTLE -> no rsp_valid, all outputs 0 immediately, depth=0.
